// File: rtl/axi_sram_slave.sv
// AXI-style burst responder on a single-port 64-bit SRAM: one burst at a time,
// writes go straight to SRAM, reads flow through a 2-entry skid buffer.
module axi_sram_slave #(
  parameter int ID_W    = 6,
  parameter int DATA_W  = 64,
  parameter int SRAM_AW = 10
) (
  input  logic                  gclk,
  input  logic                  gresetn,
  input  logic [ID_W-1:0]       aid,
  input  logic [31:0]           axi_addr,
  input  logic                  avalid,
  input  logic                  awrite,
  input  logic [3:0]            alen,
  input  logic [1:0]            asize,
  input  logic [1:0]            aburst,
  output logic                  aready,
  input  logic [ID_W-1:0]       wid,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  sram_cen,
  output logic [DATA_W/8-1:0]   sram_wen,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_W-1:0]     sram_datain,
  input  logic [DATA_W-1:0]     sram_dataout
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                infl_q, infl_d;
  logic                infl_last_q, infl_last_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_W-1:0]   b0_data_q, b0_data_d, b1_data_q, b1_data_d;
  logic                b0_last_q, b0_last_d, b1_last_q, b1_last_d;

  logic                wr_fire, rd_issue, pop, room, last_beat;
  logic [SRAM_AW-1:0]  addr_nxt;

  // Transfer size, write ID, wlast and address bits outside the SRAM word are don't-cares.
  logic unused_inputs;
  assign unused_inputs = ^{asize, wid, wlast, axi_addr[31:SRAM_AW+3], axi_addr[2:0]};

  function automatic logic [SRAM_AW-1:0] next_addr(input logic [SRAM_AW-1:0] a,
                                                   input logic [3:0] len,
                                                   input logic [1:0] burst);
    logic [SRAM_AW-1:0] mask;
    logic [SRAM_AW-1:0] inc;
    mask = {{(SRAM_AW-4){1'b0}}, len};
    inc  = a + SRAM_AW'(1);
    if (burst == 2'b00) begin
      return a;
    end else if (burst == 2'b10 && (len inside {4'd1, 4'd3, 4'd7, 4'd15})) begin
      return (a & ~mask) | (inc & mask);
    end
    return inc;
  endfunction

  always_comb begin
    aready    = gresetn && (state_q == IDLE);
    wready    = gresetn && (state_q == WR);
    wr_fire   = wready && wvalid;
    rvalid    = (occ_q != 2'd0);
    pop       = rvalid && rready;
    last_beat = (cnt_q[3:0] == len_q);
    addr_nxt  = next_addr(addr_q, len_q, burst_q);
    // Count the slot freed by a same-cycle pop so a streaming read never bubbles.
    case (occ_q)
      2'd0:    room = 1'b1;
      2'd1:    room = pop || !infl_q;
      default: room = pop && !infl_q;
    endcase
    rd_issue    = gresetn && (state_q == RD) && (cnt_q <= {1'b0, len_q}) && room;
    sram_cen    = !(wr_fire || rd_issue);
    sram_wen    = wr_fire ? ~wstrb : '1;
    sram_datain = wr_fire ? wdata : '0;
    sram_addr   = addr_q;
    rid         = id_q;
    rdata       = b0_data_q;
    rlast       = b0_last_q;
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    infl_d      = rd_issue;
    infl_last_d = last_beat;
    occ_d       = occ_q;
    b0_data_d   = b0_data_q;
    b0_last_d   = b0_last_q;
    b1_data_d   = b1_data_q;
    b1_last_d   = b1_last_q;

    case (state_q)
      IDLE: begin
        if (avalid && aready) begin
          id_d    = aid;
          addr_d  = axi_addr[SRAM_AW+2:3];
          len_d   = alen;
          burst_d = aburst;
          cnt_d   = 5'd0;
          state_d = awrite ? WR : RD;
        end
      end
      WR: begin
        if (wr_fire) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 5'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      RD: begin
        if (rd_issue) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 5'd1;
        end
        if (pop && b0_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entry 0 is always the head; SRAM data lands behind whatever survives the pop.
    if (infl_q) begin
      if (pop) begin
        if (occ_q == 2'd1) begin
          b0_data_d = sram_dataout;
          b0_last_d = infl_last_q;
        end else begin
          b0_data_d = b1_data_q;
          b0_last_d = b1_last_q;
          b1_data_d = sram_dataout;
          b1_last_d = infl_last_q;
        end
      end else if (occ_q == 2'd0) begin
        b0_data_d = sram_dataout;
        b0_last_d = infl_last_q;
        occ_d     = occ_q + 2'd1;
      end else begin
        b1_data_d = sram_dataout;
        b1_last_d = infl_last_q;
        occ_d     = occ_q + 2'd1;
      end
    end else if (pop) begin
      b0_data_d = b1_data_q;
      b0_last_d = b1_last_q;
      occ_d     = occ_q - 2'd1;
    end
  end

  always_ff @(posedge gclk) begin
    if (!gresetn) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= '0;
      b0_data_q   <= '0;
      b0_last_q   <= 1'b0;
      b1_data_q   <= '0;
      b1_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      b0_data_q   <= b0_data_d;
      b0_last_q   <= b0_last_d;
      b1_data_q   <= b1_data_d;
      b1_last_q   <= b1_last_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected SRAM accesses and
// R beats from a word-array reference model; a negedge monitor pops and compares.
module tb_axi_sram_slave;

  logic        gclk;
  logic        gresetn;
  logic [5:0]  aid;
  logic [31:0] axi_addr;
  logic        avalid, awrite;
  logic [3:0]  alen;
  logic [1:0]  asize, aburst;
  logic        aready;
  logic [5:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  rid;
  logic [63:0] rdata;
  logic        rlast, rvalid, rready;
  logic        sram_cen;
  logic [7:0]  sram_wen;
  logic [9:0]  sram_addr;
  logic [63:0] sram_datain, sram_dataout;

  axi_sram_slave dut (
    .gclk(gclk), .gresetn(gresetn),
    .aid(aid), .axi_addr(axi_addr), .avalid(avalid), .awrite(awrite),
    .alen(alen), .asize(asize), .aburst(aburst), .aready(aready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_datain(sram_datain), .sram_dataout(sram_dataout)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct { logic [9:0] addr; logic wr; logic [7:0] wen; logic [63:0] data; } acc_t;
  typedef struct { logic [63:0] data; logic last; logic [5:0] id; } beat_t;

  acc_t        exp_acc[$];
  beat_t       exp_r[$];
  logic [63:0] ref_mem [1024];
  logic [63:0] sram_mem [1024];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int          n_tests = 0;
  int          n_fail = 0;
  int          issued = 0;
  int          popped = 0;
  bit          started = 0;
  bit          init_done = 0;
  int          rready_mode = 0;

  function automatic logic [63:0] word_init(input int i);
    return {32'(i) * 32'h9E3779B1, 32'(i) ^ 32'hA5A50000};
  endfunction

  // Word address of beat i, from the burst rules in plain arithmetic.
  function automatic int beat_addr(input logic [31:0] addr, input int len, input int burst, input int i);
    int start, n, base;
    start = int'(addr[12:3]);
    n = len + 1;
    if (burst == 0) return start;
    if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      base = start - (start % n);
      return base + ((start % n + i) % n);
    end
    return (start + i) % 1024;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM model: registered read, byte-masked write.
  always @(posedge gclk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= word_init(i);
    end else if (!sram_cen) begin
      if (sram_wen == 8'hFF) sram_dataout <= sram_mem[sram_addr];
      else for (int b = 0; b < 8; b++)
        if (!sram_wen[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_datain[b*8 +: 8];
    end
  end

  initial begin
    logic [5:0] pat;
    int pidx;
    pat = 6'b101001;
    pidx = 0;
    rready = 1'b1;
    forever begin
      @(posedge gclk);
      #1;
      case (rready_mode)
        0: rready = 1'b1;
        1: rready = 1'($urandom_range(0, 1));
        default: begin
          rready = pat[pidx];
          pidx = (pidx + 1) % 6;
        end
      endcase
    end
  end

  always @(negedge gclk) begin : monitor
    acc_t a;
    beat_t e;
    int pop_now;
    if (!gresetn) begin
      exp_r.delete();
      exp_acc.delete();
      started = 0;
      issued = 0;
      popped = 0;
    end else begin
      pop_now = (rvalid && rready) ? 1 : 0;
      if (!sram_cen) begin
        if (sram_wen == 8'hFF) begin
          check("read_issue_room", 64'((issued - popped - pop_now) <= 1), 64'd1);
          issued++;
        end
        if (exp_acc.size() == 0) check("unexpected_sram_access", {54'd0, sram_addr}, 64'h3FF_DEAD);
        else begin
          a = exp_acc.pop_front();
          check("sram_addr", 64'(sram_addr), 64'(a.addr));
          check("sram_wen", 64'(sram_wen), 64'(a.wen));
          if (a.wr) check("sram_datain", sram_datain, a.data);
        end
      end
      if (rvalid) begin
        if (exp_r.size() == 0) check("unexpected_rvalid", 64'(rvalid), 64'd0);
        else begin
          e = exp_r[0];
          check("rdata", rdata, e.data);
          check("rlast", 64'(rlast), 64'(e.last));
          check("rid", 64'(rid), 64'(e.id));
          if (rready) begin
            void'(exp_r.pop_front());
            popped++;
            started = (exp_r.size() != 0);
          end
        end
      end else if (started && rready_mode == 0 && exp_r.size() != 0) begin
        check("r_bubble", 64'(rvalid), 64'd1);
      end
    end
  end

  task automatic send_addr(input logic [5:0] id, input logic [31:0] addr, input logic wr,
                           input logic [3:0] len, input logic [1:0] burst, output bit ok);
    aid = id; axi_addr = addr; awrite = wr; alen = len; aburst = burst;
    asize = 2'($urandom_range(0, 3));
    avalid = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge gclk);
      if (aready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("aready_timeout", 64'd0, 64'd1);
    else @(posedge gclk);
    #1 avalid = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
    bit ok;
    int a;
    send_addr(id, addr, 1'b1, len, burst, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge gclk);
        #1;
      end
      a = beat_addr(addr, int'(len), int'(burst), i);
      wvalid = 1'b1;
      wdata = wd[i];
      wstrb = ws[i];
      wid = 6'($urandom);
      wlast = (i == int'(len)) ^ ($urandom_range(0, 7) == 0);
      exp_acc.push_back('{a[9:0], 1'b1, ~ws[i], wd[i]});
      for (int b = 0; b < 8; b++)
        if (ws[i][b]) ref_mem[a][b*8 +: 8] = wd[i][b*8 +: 8];
      @(posedge gclk);
      #1;
      wvalid = 1'b0;
      wlast = 1'b0;
    end
  endtask

  task automatic start_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst);
    bit ok;
    int a;
    send_addr(id, addr, 1'b0, len, burst, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, int'(len), int'(burst), i);
      exp_acc.push_back('{a[9:0], 1'b0, 8'hFF, 64'd0});
      exp_r.push_back('{ref_mem[a], (i == int'(len)), id});
    end
    @(negedge gclk);
    check("rvalid_cycle1", 64'(rvalid), 64'd0);
    @(negedge gclk);
    check("rvalid_cycle2", 64'(rvalid), 64'd0);
    @(negedge gclk);
    check("rvalid_first", 64'(rvalid), 64'd1);
  endtask

  task automatic wait_read_done();
    bit done;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      if (exp_r.size() == 0) begin
        done = 1;
        break;
      end
      @(negedge gclk);
    end
    if (!done) check("read_timeout", 64'(exp_r.size()), 64'd0);
    @(posedge gclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [1:0]  r_burst;
    gresetn = 1'b0; avalid = 1'b0; awrite = 1'b0; aid = '0; axi_addr = '0; alen = '0;
    asize = '0; aburst = '0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = word_init(i);
    @(posedge gclk);
    #1 init_done = 1;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_rlast", 64'(rlast), 64'd0);
    check("reset_rid", 64'(rid), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_wready", 64'(wready), 64'd0);
    check("reset_aready", 64'(aready), 64'd0);
    check("reset_sram_cen", 64'(sram_cen), 64'd1);
    check("reset_sram_wen", 64'(sram_wen), 64'hFF);
    check("reset_sram_addr", 64'(sram_addr), 64'd0);
    check("reset_sram_datain", sram_datain, 64'd0);
    @(posedge gclk);
    #1 gresetn = 1'b1;
    @(negedge gclk);
    check("aready_after_reset", 64'(aready), 64'd1);
    @(posedge gclk);
    #1;

    $display("[TB] single write then read");
    rready_mode = 0;
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    do_write(6'h05, 32'h40, 4'd0, 2'b01);
    start_read(6'h2A, 32'h40, 4'd0, 2'b01);
    wait_read_done();

    $display("[TB] INCR burst");
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(i); ws[i] = 8'hFF;
    end
    do_write(6'h01, 32'h100, 4'd3, 2'b01);
    start_read(6'h02, 32'h100, 4'd3, 2'b01);
    wait_read_done();

    $display("[TB] WRAP and reserved burst");
    start_read(6'h03, 32'h18, 4'd3, 2'b10);
    wait_read_done();
    start_read(6'h04, 32'h18, 4'd3, 2'b11);
    wait_read_done();

    $display("[TB] partial strobes");
    wd[0] = '1; ws[0] = 8'hFF;
    do_write(6'h06, 32'h0, 4'd0, 2'b01);
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(6'h06, 32'h0, 4'd0, 2'b01);
    start_read(6'h07, 32'h0, 4'd0, 2'b01);
    wait_read_done();

    $display("[TB] backpressure");
    rready_mode = 2;
    start_read(6'h08, 32'h200, 4'd7, 2'b01);
    wait_read_done();

    $display("[TB] reset mid-burst");
    base = popped;
    start_read(6'h09, 32'h100, 4'd7, 2'b01);
    for (int k = 0; k < 100 && (popped - base) < 2; k++) @(negedge gclk);
    check("midburst_two_beats", 64'((popped - base) >= 2), 64'd1);
    @(posedge gclk);
    #1 gresetn = 1'b0;
    @(posedge gclk);
    @(negedge gclk);
    check("midreset_rvalid", 64'(rvalid), 64'd0);
    check("midreset_sram_cen", 64'(sram_cen), 64'd1);
    check("midreset_aready", 64'(aready), 64'd0);
    @(posedge gclk);
    #1 gresetn = 1'b1;
    @(negedge gclk);
    check("aready_after_midreset", 64'(aready), 64'd1);
    @(posedge gclk);
    #1 rready_mode = 0;
    start_read(6'h0A, 32'h100, 4'd3, 2'b01);
    wait_read_done();

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      r_addr = $urandom;
      r_len = 4'($urandom_range(0, 15));
      r_burst = 2'($urandom_range(0, 3));
      rready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = 8'($urandom);
        end
        do_write(6'($urandom), r_addr, r_len, r_burst);
      end else begin
        start_read(6'($urandom), r_addr, r_len, r_burst);
        wait_read_done();
      end
    end

    repeat (3) @(posedge gclk);
    @(negedge gclk);
    check("leftover_sram_accesses", 64'(exp_acc.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
